// File: rtl/y_row_unpack.sv
// Y RAM read-side unpacker: splits a 256-bit row into four 48-bit elements streamed with a {row, slot} index.
// Optional one-row spare buffer for zero-bubble row turnaround: define Y_ROW_UNPACK_PREFETCH_EN.
//
// state  | meaning
// IDLE   | no active row; ready for a new row, no element presented
// STREAM | active row buffered; presenting element at slot pointer
module y_row_unpack (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         Clear,
  input  logic         RowValid,
  output logic         RowReady,
  input  logic [255:0] Y_ramRow,
  input  logic [1:0]   StartSlot,
  output logic         ElemValid,
  input  logic         ElemReady,
  output logic [47:0]  Element,
  output logic [12:0]  PosElement,
  output logic         LastInRow
);

  typedef enum logic {IDLE, STREAM} stateT;

  stateT            state, stateNext;
  logic [3:0][47:0] rowLanes, activeLanes;
  logic [1:0]       slot;
  logic [10:0]      rowIdx;
  logic             rowAcc, elemAcc, lastAcc;
  logic             loadActive, advanceSlot, bumpRow;
  logic             unusedLaneTops;
`ifdef Y_ROW_UNPACK_PREFETCH_EN
  logic [3:0][47:0] spareLanes;
  logic [1:0]       spareStart;
  logic             spareValid;
  logic             loadSpare, loadFromSpare;
`endif

  // Slot k lives in the low 48 bits of 64-bit lane k, counted from the top of the row.
  always_comb begin
    for (int k = 0; k < 4; k++) rowLanes[k] = Y_ramRow[239-64*k -: 48];
  end

  assign unusedLaneTops = ^{Y_ramRow[255:240], Y_ramRow[191:176], Y_ramRow[127:112], Y_ramRow[63:48]};

  always_comb begin
    stateNext   = state;
    RowReady    = 1'b0;
    ElemValid   = 1'b0;
    loadActive  = 1'b0;
    advanceSlot = 1'b0;
    bumpRow     = 1'b0;
`ifdef Y_ROW_UNPACK_PREFETCH_EN
    loadSpare     = 1'b0;
    loadFromSpare = 1'b0;
`endif
    case (state)
      IDLE:   RowReady = 1'b1;
      STREAM: begin
        ElemValid = 1'b1;
`ifdef Y_ROW_UNPACK_PREFETCH_EN
        RowReady  = !spareValid;
`endif
      end
      default: ;
    endcase

    rowAcc  = RowValid & RowReady;
    elemAcc = ElemValid & ElemReady;
    lastAcc = elemAcc & (slot == 2'd3);

    case (state)
      IDLE: begin
        if (rowAcc) begin
          loadActive = 1'b1;
          stateNext  = STREAM;
        end
      end
      STREAM: begin
        if (elemAcc && !lastAcc) advanceSlot = 1'b1;
        if (lastAcc) begin
          bumpRow = 1'b1;
`ifdef Y_ROW_UNPACK_PREFETCH_EN
          // A row arriving with the last handshake can only land here while spare is empty.
          if (spareValid)  loadFromSpare = 1'b1;
          else if (rowAcc) loadActive    = 1'b1;
          else             stateNext     = IDLE;
`else
          stateNext = IDLE;
`endif
        end
`ifdef Y_ROW_UNPACK_PREFETCH_EN
        if (rowAcc && !lastAcc) loadSpare = 1'b1;
`endif
      end
      default: stateNext = IDLE;
    endcase

    Element    = ElemValid ? activeLanes[slot] : 48'd0;
    PosElement = ElemValid ? {rowIdx, slot} : 13'd0;
    LastInRow  = ElemValid && (slot == 2'd3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      activeLanes <= '0;
      slot        <= 2'd0;
      rowIdx      <= 11'd0;
`ifdef Y_ROW_UNPACK_PREFETCH_EN
      spareLanes  <= '0;
      spareStart  <= 2'd0;
      spareValid  <= 1'b0;
`endif
    end else if (Clear) begin
      state  <= IDLE;
      slot   <= 2'd0;
      rowIdx <= 11'd0;
`ifdef Y_ROW_UNPACK_PREFETCH_EN
      spareValid <= 1'b0;
`endif
    end else begin
      state <= stateNext;
      if (loadActive) begin
        activeLanes <= rowLanes;
        slot        <= StartSlot;
`ifdef Y_ROW_UNPACK_PREFETCH_EN
      end else if (loadFromSpare) begin
        activeLanes <= spareLanes;
        slot        <= spareStart;
`endif
      end else if (advanceSlot) begin
        slot <= slot + 2'd1;
      end
      if (bumpRow) rowIdx <= rowIdx + 11'd1;
`ifdef Y_ROW_UNPACK_PREFETCH_EN
      if (loadSpare) begin
        spareLanes <= rowLanes;
        spareStart <= StartSlot;
        spareValid <= 1'b1;
      end else if (loadFromSpare) begin
        spareValid <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_y_row_unpack.sv
// Directed bench for y_row_unpack: ordering, partial rows, stalls, throughput, index wrap, flush, async reset.
module tb_y_row_unpack;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         Clear = 1'b0;
  logic         RowValid = 1'b0;
  logic         RowReady;
  logic [255:0] Y_ramRow = '0;
  logic [1:0]   StartSlot = 2'd0;
  logic         ElemValid;
  logic         ElemReady = 1'b0;
  logic [47:0]  Element;
  logic [12:0]  PosElement;
  logic         LastInRow;

  int vectors = 0;
  int miscompares = 0;

`ifdef Y_ROW_UNPACK_PREFETCH_EN
  localparam int ROW_CYCLES = 4;
`else
  localparam int ROW_CYCLES = 5;
`endif

  y_row_unpack dut (
    .clk(clk), .rst_n(rst_n), .Clear(Clear),
    .RowValid(RowValid), .RowReady(RowReady), .Y_ramRow(Y_ramRow), .StartSlot(StartSlot),
    .ElemValid(ElemValid), .ElemReady(ElemReady), .Element(Element),
    .PosElement(PosElement), .LastInRow(LastInRow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mkRow(input logic [47:0] a, input logic [47:0] b,
                                         input logic [47:0] c, input logic [47:0] d);
    return {16'hFFFF, a, 16'hFFFF, b, 16'hFFFF, c, 16'hFFFF, d};
  endfunction

  task automatic expElem(input string tag, input logic [47:0] e, input logic [12:0] p, input logic last);
    chk({tag, ".valid"}, 64'(ElemValid), 64'(1'b1));
    chk({tag, ".elem"},  64'(Element),   64'(e));
    chk({tag, ".pos"},   64'(PosElement), 64'(p));
    chk({tag, ".last"},  64'(LastInRow), 64'(last));
  endtask

  task automatic drain();
    bit ok = 1'b0;
    RowValid  = 1'b0;
    ElemReady = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (!ElemValid && RowReady) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("drain", 64'(ok), 64'(1'b1));
  endtask

  initial begin
    logic [47:0] t1 [4];
    logic [47:0] la [4];
    logic [7:0]  pat;
    int          s, nAcc, cyc;
    int          accCyc [5];
    bit          found;

    t1[0] = 48'h111111111111; t1[1] = 48'h222222222222;
    t1[2] = 48'h333333333333; t1[3] = 48'h444444444444;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst.rowReady", 64'(RowReady), 64'(1'b1));
    chk("rst.elemValid", 64'(ElemValid), 64'(1'b0));
    chk("rst.element", 64'(Element), 64'(48'd0));
    chk("rst.pos", 64'(PosElement), 64'(13'd0));
    chk("rst.last", 64'(LastInRow), 64'(1'b0));
    rst_n = 1'b1;
    @(negedge clk);

    // full row, in-order, no upper-bit leakage, one-cycle latency
    ElemReady = 1'b1;
    StartSlot = 2'd0;
    Y_ramRow  = mkRow(t1[0], t1[1], t1[2], t1[3]);
    RowValid  = 1'b1;
    chk("t1.rowReady", 64'(RowReady), 64'(1'b1));
    @(negedge clk);
    RowValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expElem("t1", t1[i], 13'(i), (i == 3));
      @(negedge clk);
    end
    chk("t1.bubbleValid", 64'(ElemValid), 64'(1'b0));
    chk("t1.bubbleReady", 64'(RowReady), 64'(1'b1));

    // StartSlot=2 on row 1, then StartSlot=1 on row 2
    for (int i = 0; i < 4; i++) la[i] = 48'hA00000000000 + 48'(i);
    Y_ramRow  = mkRow(la[0], la[1], la[2], la[3]);
    StartSlot = 2'd2;
    RowValid  = 1'b1;
    @(negedge clk);
    RowValid = 1'b0;
    expElem("t2a.s2", la[2], 13'd6, 1'b0);
    @(negedge clk);
    expElem("t2a.s3", la[3], 13'd7, 1'b1);
    @(negedge clk);
    chk("t2a.onlyTwo", 64'(ElemValid), 64'(1'b0));
    for (int i = 0; i < 4; i++) la[i] = 48'hB00000000000 + 48'(i);
    Y_ramRow  = mkRow(la[0], la[1], la[2], la[3]);
    StartSlot = 2'd1;
    RowValid  = 1'b1;
    @(negedge clk);
    RowValid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      expElem("t2b", la[i], 13'(8 + i), (i == 3));
      @(negedge clk);
    end

    // back-pressure: ElemReady pattern 1,0,0,1,0,1,0,1 on row 3
    for (int i = 0; i < 4; i++) la[i] = 48'hC00000000000 + 48'(i);
    Y_ramRow  = mkRow(la[0], la[1], la[2], la[3]);
    StartSlot = 2'd0;
    RowValid  = 1'b1;
    @(negedge clk);
    RowValid = 1'b0;
    pat = 8'b1010_1001;
    s   = 0;
    for (int c = 0; c < 8; c++) begin
      ElemReady = pat[c];
      chk("t3.valid", 64'(ElemValid), 64'(1'b1));
      chk("t3.elem", 64'(Element), 64'(la[s]));
      chk("t3.pos", 64'(PosElement), 64'({11'd3, 2'(s)}));
      @(negedge clk);
      if (pat[c]) s++;
    end
    chk("t3.doneAfter4", 64'(ElemValid), 64'(1'b0));
    ElemReady = 1'b1;

    // throughput with a fresh row at every opportunity
    StartSlot = 2'd0;
    RowValid  = 1'b1;
    nAcc = 0;
    cyc  = 0;
    while (cyc < 100) begin
      Y_ramRow = mkRow(48'(nAcc), 48'(nAcc + 1), 48'(nAcc + 2), 48'(nAcc + 3));
      if (RowReady) begin
        accCyc[nAcc] = cyc;
        nAcc++;
        if (nAcc == 5) break;
      end
      @(negedge clk);
      cyc++;
    end
    chk("t4.accepts", 64'(nAcc), 64'(5));
    @(negedge clk);
    RowValid = 1'b0;
    if (nAcc == 5) begin
      chk("t4.period34", 64'(accCyc[3] - accCyc[2]), 64'(ROW_CYCLES));
      chk("t4.period45", 64'(accCyc[4] - accCyc[3]), 64'(ROW_CYCLES));
    end
    drain();

    // PosElement wrap 13'h1FFF -> 13'h0000
    Y_ramRow  = mkRow(t1[0], t1[1], t1[2], t1[3]);
    StartSlot = 2'd0;
    RowValid  = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 15000; i++) begin
      @(negedge clk);
      if (ElemValid && PosElement == 13'h1FFF) begin
        found = 1'b1;
        break;
      end
    end
    chk("t5.reach1FFF", 64'(found), 64'(1'b1));
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ElemValid) begin
        found = 1'b1;
        break;
      end
    end
    chk("t5.nextSeen", 64'(found), 64'(1'b1));
    chk("t5.wrapPos", 64'(PosElement), 64'(13'd0));
    chk("t5.wrapElem", 64'(Element), 64'(t1[0]));
    drain();

    // Clear at slot 1 with a colliding row
    for (int i = 0; i < 4; i++) la[i] = 48'hD00000000000 + 48'(i);
    Y_ramRow  = mkRow(la[0], la[1], la[2], la[3]);
    StartSlot = 2'd0;
    RowValid  = 1'b1;
    @(negedge clk);
    RowValid = 1'b0;
    @(negedge clk);
    chk("t6.atSlot1", 64'(Element), 64'(la[1]));
    Clear     = 1'b1;
    RowValid  = 1'b1;
    Y_ramRow  = mkRow(48'hDEADDEADDEAD, 48'hDEADDEADDEAD, 48'hDEADDEADDEAD, 48'hDEADDEADDEAD);
    @(negedge clk);
    Clear    = 1'b0;
    RowValid = 1'b0;
    chk("t6.clrValid", 64'(ElemValid), 64'(1'b0));
    chk("t6.clrReady", 64'(RowReady), 64'(1'b1));
    chk("t6.clrElem", 64'(Element), 64'(48'd0));
    @(negedge clk);
    chk("t6.discarded", 64'(ElemValid), 64'(1'b0));
    for (int i = 0; i < 4; i++) la[i] = 48'hE00000000000 + 48'(i);
    Y_ramRow = mkRow(la[0], la[1], la[2], la[3]);
    RowValid = 1'b1;
    @(negedge clk);
    RowValid = 1'b0;
    expElem("t6.after", la[0], 13'd0, 1'b0);
    drain();

    // async reset mid-stream
    Y_ramRow = mkRow(t1[0], t1[1], t1[2], t1[3]);
    RowValid = 1'b1;
    @(negedge clk);
    RowValid = 1'b0;
    chk("t7.streaming", 64'(ElemValid), 64'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    chk("t7.rstValid", 64'(ElemValid), 64'(1'b0));
    chk("t7.rstReady", 64'(RowReady), 64'(1'b1));
    chk("t7.rstPos", 64'(PosElement), 64'(13'd0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t7.rowLost", 64'(ElemValid), 64'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/y_row_unpack.md
# y_row_unpack

Streaming unpacker on the read side of the Y RAM. It accepts one 256-bit Y RAM row per handshake and splits it into four 48-bit element slots. It emits them one at a time over a valid/ready interface, each tagged with a 13-bit PosElement index. Slot layout is the padder's: slot k occupies bits [239-64k : 192-64k], element in low 48 bits of each 64-bit lane, upper 16 bits of each lane ignored.

## Interface
Parameters:
- none. Widths are fixed: row 256, element 48, index 13.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- Clear  in  1  synchronous flush: drops buffered rows, zeroes row index.
- RowValid  in  1  Y_ramRow/StartSlot valid.
- RowReady  out  1  unpacker can accept a row this cycle.
- Y_ramRow  in  256  row data.
- StartSlot  in  2  first slot to emit from this row (slots StartSlot..3 emitted).
- ElemValid  out  1  Element/PosElement/LastInRow valid.
- ElemReady  in  1  downstream accepts element.
- Element  out  48  extracted element; 0 when ElemValid=0.
- PosElement  out  13  {RowIdx[10:0], slot[1:0]}.
- LastInRow  out  1  current element is slot 3.

## Operation
- Row accept: RowValid & RowReady at an edge. Row and StartSlot are latched into the active buffer, and slot pointer := StartSlot.
- FSM: IDLE, STREAM.
  - IDLE: RowReady=1, ElemValid=0. On row accept -> STREAM.
  - STREAM: ElemValid=1, Element = lane[slot][47:0], PosElement={RowIdx,slot}, LastInRow=(slot==3).
    - ElemValid & ElemReady with slot<3: slot+1.
    - Handshake with slot==3: RowIdx+1 (wraps 2047->0), then -> IDLE, or load next row (prefetch build).
- Element selection uses registered buffer and slot only. No combinational path from Y_ramRow to Element.
- ElemValid held with stable Element/PosElement until accepted (no retraction).
- Clear, highest priority, registered effect next cycle:
  - state -> IDLE, all buffers invalid, RowIdx=0, slot=0.
  - A row handshake in the same cycle is discarded.
  - An element handshake in the same cycle is treated as consumed but has no further effect.
- Upper 16 bits of each lane are never output.

## Timing
- Reset values: RowReady=1, ElemValid=0, Element=0, PosElement=0, LastInRow=0. FSM=IDLE, RowIdx=0.
- Reset mid-stream: immediate (async) return to reset values. The buffered row is lost.
- Latency: row accepted at edge N -> first element valid after edge N (cycle N+1).
- Full row with ElemReady held 1: 4 elements in 4 consecutive cycles.
- Without prefetch:
  - RowReady=0 throughout STREAM.
  - Last handshake at edge M -> IDLE in cycle M+1 (RowReady=1, ElemValid=0), one bubble per row.
- Back-pressure: ElemReady=0 freezes slot, outputs and RowIdx indefinitely.

## Configuration
- Macro Y_ROW_UNPACK_PREFETCH_EN.
- Defined: adds a one-row spare buffer.
  - RowReady = !spare_valid in STREAM, 1 in IDLE.
  - A row accepted during STREAM goes to spare.
  - On the slot-3 handshake with spare valid: spare moves to active, slot := its StartSlot, and the state stays STREAM. The next element is valid the following cycle with zero bubble.
  - A row accepted in the same cycle as the slot-3 handshake while spare is empty loads directly into active.
  - Clear also invalidates spare.
- Undefined: no spare register. Behaviour exactly as in Timing "without prefetch".

## Test plan
- Reset, then row with lanes 0..3 = 48'h111111111111, 48'h222222222222, 48'h333333333333, 48'h444444444444, each lane's top 16 bits set to 16'hFFFF, StartSlot=0, ElemReady=1. Required response:
  - Elements appear in that order with PosElement 0,1,2,3.
  - LastInRow only on the 4th element.
  - No FFFF bits leak into Element.
- Row with StartSlot=2 -> exactly two elements with PosElement 2 and 3. The next row's elements start at PosElement 4+StartSlot.
- ElemReady toggled 1,0,0,1,... -> Element/PosElement stable while stalled, no element dropped or duplicated, 4 handshakes total.
- Continuous RowValid with a fresh row every opportunity:
  - Without macro: 5 cycles per row.
  - With Y_ROW_UNPACK_PREFETCH_EN: 4 cycles per row, RowReady=0 only while spare is full.
- 2048 full rows -> PosElement wraps from 13'h1FFF to 13'h0000.
- Clear asserted mid-row at slot 1, with RowValid=1 the same cycle -> next cycle ElemValid=0, RowReady=1. The next accepted row emits PosElement 0; the discarded row never appears.
